// File: rtl/pu_riscv_ahb3lite_pkg.sv
// Shared AHB-Lite definitions: transfer/size/response encodings, the
// AHB-to-APB bridge state type, and the APB write-strobe helper.
package pu_riscv_ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } bridge_state_t;

  // Byte lanes of a 32-bit APB bus touched by a write; reads strobe nothing.
  function automatic logic [3:0] apb_strobe(input logic       write,
                                            input logic [2:0] size,
                                            input logic [1:0] addr);
    logic [3:0] strb;
    strb = 4'b0000;
    if (write) begin
      case (size)
        HSIZE_BYTE:  strb = 4'b0001 << addr;
        HSIZE_HWORD: strb = 4'b0011 << {addr[1], 1'b0};
        default:     strb = 4'b1111;
      endcase
    end
    return strb;
  endfunction

endpackage

// File: rtl/pu_riscv_ahb3lite2apb4_bridge.sv
// AHB-Lite slave to APB4 master bridge with wait-state insertion, two-cycle
// error responses and an optional ACCESS-phase timeout.
module pu_riscv_ahb3lite2apb4_bridge
  import pu_riscv_ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PADDR_SIZE = 8,
  parameter int PDATA_SIZE = 32,
  parameter int TIMEOUT    = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic [HADDR_SIZE-1:0]   HADDR,
  input  logic [HDATA_SIZE-1:0]   HWDATA,
  output logic [HDATA_SIZE-1:0]   HRDATA,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [1:0]              HTRANS,
  input  logic                    HMASTLOCK,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [2:0]              PPROT,
  output logic                    PWRITE,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int STRB_W = PDATA_SIZE / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  bridge_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic accept, can_accept, timeout_hit;

  assign accept      = HSEL & HREADY & HTRANS[1];
  assign can_accept  = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
  assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept) state_nxt = (HSIZE > HSIZE_WORD) ? ST_ERR1 : ST_LOAD;
        else        state_nxt = ST_IDLE;
      end
      ST_LOAD:  state_nxt = ST_SETUP;
      ST_SETUP: state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY)           state_nxt = PSLVERR ? ST_ERR1 : ST_DONE;
        else if (timeout_hit) state_nxt = ST_ERR1;
      end
      ST_ERR1:  state_nxt = ST_ERR2;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // AHB response is a pure decode of the state register.
  assign HREADYOUT = ~((state == ST_LOAD) || (state == ST_SETUP) ||
                       (state == ST_ACCESS) || (state == ST_ERR1));
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign PSEL      = (state == ST_SETUP) || (state == ST_ACCESS);
  assign PENABLE   = (state == ST_ACCESS);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PPROT  <= 3'b000;
      PSTRB  <= '0;
      PWDATA <= '0;
      HRDATA <= '0;
    end else begin
      state <= state_nxt;
      if (can_accept && accept) begin
        PADDR  <= HADDR[PADDR_SIZE-1:0];
        PWRITE <= HWRITE;
        PPROT  <= {~HPROT[0], 1'b0, HPROT[1]};
        PSTRB  <= STRB_W'(apb_strobe(HWRITE, HSIZE, HADDR[1:0]));
      end
      if ((state == ST_LOAD) && PWRITE) PWDATA <= HWDATA;
      if (state == ST_SETUP)       cnt <= '0;
      else if (state == ST_ACCESS) cnt <= cnt + CNT_W'(1);
      if ((state == ST_ACCESS) && PREADY && !PSLVERR) HRDATA <= PRDATA;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{HBURST, HMASTLOCK, HPROT[3:2], HTRANS[0],
                       HADDR[HADDR_SIZE-1:PADDR_SIZE]};

endmodule

// File: tb/tb_pu_riscv_ahb3lite2apb4_bridge.sv
// Scoreboard bench for the AHB-Lite to APB4 bridge: directed transfers push
// expected APB and AHB responses; a monitor pops and compares them.
module tb_pu_riscv_ahb3lite2apb4_bridge;
  import pu_riscv_ahb3lite_pkg::*;

  logic        clk = 1'b0;
  logic        hreset, hsel, hwrite, hmastlock, hready, hreadyout, hresp;
  logic [31:0] haddr, hwdata, hrdata;
  logic [2:0]  hsize, hburst, pprot;
  logic [3:0]  hprot, pstrb;
  logic [1:0]  htrans;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  pu_riscv_ahb3lite2apb4_bridge #(.TIMEOUT(4)) dut (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(hrdata), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready),
    .HREADYOUT(hreadyout), .HRESP(hresp), .PSEL(psel), .PENABLE(penable),
    .PPROT(pprot), .PWRITE(pwrite), .PSTRB(pstrb), .PADDR(paddr),
    .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr));

  typedef struct {
    logic [7:0] addr; logic write; logic [3:0] strb; logic [31:0] wdata;
    logic [2:0] prot; int acc;
  } apb_exp_t;
  typedef struct { int lat; logic resp; logic chk_rdata; logic [31:0] rdata; } rsp_exp_t;
  typedef struct { int waits; logic err; logic [31:0] rdata; } slv_cfg_t;

  apb_exp_t apb_q[$];
  rsp_exp_t rsp_q[$];
  slv_cfg_t slv_q[$];
  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // APB slave: each access takes its wait count / error / read data from slv_q.
  slv_cfg_t cur_slv = '{waits: 0, err: 1'b0, rdata: 32'h0};
  int acc_cnt = 0;
  always @(posedge clk) begin
    if (psel && !penable && slv_q.size() > 0) cur_slv <= slv_q.pop_front();
    if (psel && penable) acc_cnt <= acc_cnt + 1;
    else                 acc_cnt <= 0;
  end
  always_comb begin
    pready  = psel && penable && (acc_cnt >= cur_slv.waits);
    pslverr = pready && cur_slv.err;
    prdata  = cur_slv.rdata;
  end

  // Monitor: evaluates each cycle at the negedge using the accept/reset
  // conditions sampled on the previous negedge (the ones the DUT saw).
  initial begin
    logic a_prev = 1'b0, r_prev = 1'b1, inflight = 1'b0, in_apb = 1'b0;
    logic prev_rdy = 1'b1, prev_resp = 1'b0;
    int cyc = 0, acc_seen = 0;
    apb_exp_t ca;
    rsp_exp_t cr;
    forever begin
      @(negedge clk);
      if (r_prev) begin
        inflight = 1'b0;
        in_apb   = 1'b0;
        rsp_q.delete();
      end else begin
        if (a_prev) begin
          if (inflight) check("accept_while_busy", 32'd1, 32'd0);
          inflight = 1'b1;
          cyc = 1;
        end else if (inflight) cyc++;

        if (psel && !penable) begin
          if (apb_q.size() == 0) check("unexpected_psel", {31'd0, psel}, 32'd0);
          else begin
            ca = apb_q.pop_front();
            check("setup_cycle", cyc, 2);
            check("paddr", {24'd0, paddr}, {24'd0, ca.addr});
            check("pwrite", {31'd0, pwrite}, {31'd0, ca.write});
            check("pstrb", {28'd0, pstrb}, {28'd0, ca.strb});
            check("pprot", {29'd0, pprot}, {29'd0, ca.prot});
            if (ca.write) check("pwdata", pwdata, ca.wdata);
            in_apb = 1'b1;
            acc_seen = 0;
          end
        end else if (psel && penable && in_apb) begin
          acc_seen++;
          check("paddr_stable", {24'd0, paddr}, {24'd0, ca.addr});
          check("pstrb_stable", {28'd0, pstrb}, {28'd0, ca.strb});
          if (ca.write) check("pwdata_stable", pwdata, ca.wdata);
        end else if (in_apb) begin
          check("access_cycles", acc_seen, ca.acc);
          in_apb = 1'b0;
        end

        if (inflight && hreadyout) begin
          if (rsp_q.size() == 0) check("unexpected_response", 32'd1, 32'd0);
          else begin
            cr = rsp_q.pop_front();
            check("latency", cyc, cr.lat);
            check("hresp", {31'd0, hresp}, {31'd0, cr.resp});
            if (cr.resp) check("err1_phase", {30'd0, prev_rdy, prev_resp}, 32'd1);
            if (cr.chk_rdata) check("hrdata", hrdata, cr.rdata);
          end
          inflight = 1'b0;
        end
      end
      prev_rdy  = hreadyout;
      prev_resp = hresp;
      a_prev    = hsel & hreadyout & htrans[1];
      r_prev    = hreset;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one address phase and return once it has been accepted.
  task automatic issue(input logic [31:0] addr, input logic write, input logic [2:0] size,
                       input logic [3:0] prot, input logic [31:0] wdata, input int waits,
                       input logic err, input logic [31:0] rdata, input logic [3:0] exp_strb,
                       input logic [2:0] exp_prot, input int exp_acc, input int exp_lat,
                       input logic exp_resp);
    logic rdy = 1'b0;
    if (exp_acc > 0) begin
      slv_q.push_back('{waits: waits, err: err, rdata: rdata});
      apb_q.push_back('{addr: addr[7:0], write: write, strb: exp_strb, wdata: wdata,
                        prot: exp_prot, acc: exp_acc});
    end
    rsp_q.push_back('{lat: exp_lat, resp: exp_resp, chk_rdata: !write && !exp_resp,
                      rdata: rdata});
    hsel = 1'b1; haddr = addr; hwrite = write; hsize = size; hprot = prot;
    htrans = HTRANS_NONSEQ;
    for (int i = 0; i < 64 && !rdy; i++) begin
      @(negedge clk);
      rdy = hreadyout;
      @(posedge clk);
      #1;
    end
    if (!rdy) check("accept_timeout", 32'd0, 32'd1);
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = wdata;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_psel"}, {31'd0, psel}, 32'd0);
    check({tag, "_penable"}, {31'd0, penable}, 32'd0);
    check({tag, "_pwrite"}, {31'd0, pwrite}, 32'd0);
    check({tag, "_paddr"}, {24'd0, paddr}, 32'd0);
    check({tag, "_pwdata"}, pwdata, 32'd0);
    check({tag, "_pstrb"}, {28'd0, pstrb}, 32'd0);
    check({tag, "_pprot"}, {29'd0, pprot}, 32'd0);
    check({tag, "_hrdata"}, hrdata, 32'd0);
    check({tag, "_hreadyout"}, {31'd0, hreadyout}, 32'd1);
    check({tag, "_hresp"}, {31'd0, hresp}, 32'd0);
  endtask

  initial begin
    hreset = 1'b1; hsel = 1'b0; haddr = '0; hwdata = '0; hwrite = 1'b0;
    hsize = HSIZE_WORD; hburst = 3'b000; hprot = 4'b0000; htrans = HTRANS_IDLE;
    hmastlock = 1'b0;
    idle(3);
    check_reset_values("por");
    hreset = 1'b0;
    idle(2);

    //     addr   wr  size prot     wdata         w  e  rdata         strb     pprot  acc lat resp
    issue(32'h34, 1, 3'd2, 4'b0011, 32'hDEADBEEF, 0, 0, 32'h0,        4'b1111, 3'b001, 1, 4, 0);
    idle(2);
    issue(32'h13, 1, 3'd0, 4'b0000, 32'h5A000000, 2, 0, 32'h0,        4'b1000, 3'b100, 3, 6, 0);
    issue(32'h22, 1, 3'd1, 4'b0010, 32'hBEEF0000, 0, 0, 32'h0,        4'b1100, 3'b101, 1, 4, 0);
    idle(2);
    issue(32'h80, 0, 3'd2, 4'b0001, 32'h0,        0, 1, 32'h12345678, 4'b0000, 3'b000, 1, 5, 1);
    idle(2);
    issue(32'h04, 0, 3'd2, 4'b0011, 32'h0,        0, 0, 32'h11112222, 4'b0000, 3'b001, 1, 4, 0);
    issue(32'h08, 0, 3'd2, 4'b0011, 32'h0,        0, 0, 32'h33334444, 4'b0000, 3'b001, 1, 4, 0);
    issue(32'h0C, 0, 3'd2, 4'b0011, 32'h0,        1, 0, 32'h55556666, 4'b0000, 3'b001, 2, 5, 0);
    idle(3);
    issue(32'h40, 1, 3'd3, 4'b0011, 32'h01020304, 0, 0, 32'h0,        4'b0000, 3'b001, 0, 2, 1);
    issue(32'h44, 1, 3'd2, 4'b0011, 32'hCAFEF00D, 0, 0, 32'h0,        4'b1111, 3'b001, 1, 4, 0);
    idle(3);
    issue(32'h20, 0, 3'd2, 4'b0011, 32'h0,     1000, 0, 32'h0,        4'b0000, 3'b001, 4, 8, 1);
    idle(12);

    // Reset in the middle of a stalled ACCESS phase.
    issue(32'h60, 0, 3'd2, 4'b0011, 32'h0,     1000, 0, 32'h0,        4'b0000, 3'b001, 1, 4, 0);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = psel && penable;
      end
      if (!seen) check("access_not_reached", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    hreset = 1'b1;
    idle(1);
    check_reset_values("mid_reset");
    hreset = 1'b0;
    idle(2);
    issue(32'h10, 0, 3'd2, 4'b0011, 32'h0,        0, 0, 32'h0BADCAFE, 4'b0000, 3'b001, 1, 4, 0);

    for (int i = 0; i < 100 && (rsp_q.size() != 0 || apb_q.size() != 0); i++) idle(1);
    idle(3);
    check("rsp_queue_drained", rsp_q.size(), 0);
    check("apb_queue_drained", apb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
